// File: rtl/revo_word_receiver.sv
// Revolution-marker word receiver: finds the 0->1 revo edge in each deserialized word,
// locks to the revolution period and reports strobe, bit phase, lock state and error stats.
// Optional feature macro: REVO_FLYWHEEL_EN (keep emitting revo through missed periods while locked).
module revo_word_receiver #(
    parameter int BIT_DEPTH         = 8,
    parameter int REVO_PERIOD_WORDS = 640,
    parameter int LOCK_COUNT        = 4,
    parameter int MAX_MISSES        = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [BIT_DEPTH-1:0] word_in,
    output logic                 revo,
    output logic [2:0]           revo_bit_phase,
    output logic                 locked,
    output logic                 period_error,
    output logic [15:0]          error_count,
    output logic [15:0]          measured_period
);

    localparam logic [15:0] PERIOD = 16'(REVO_PERIOD_WORDS);
    localparam logic [7:0]  LOCK_C = 8'(LOCK_COUNT);
    localparam logic [7:0]  MISS_C = 8'(MAX_MISSES);
    localparam logic [15:0] SAT    = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 prev_lsb_r;
    logic [15:0]          dist_r;
    logic [2:0]           ref_phase_r;
    logic [2:0]           ref_phase_s;
    logic [7:0]           matches_r;
    logic [7:0]           matches_s;
    logic [7:0]           misses_r;
    logic [7:0]           misses_s;
    logic                 revo_r;
    logic [2:0]           phase_r;
    logic                 locked_r;
    logic                 err_r;
    logic [15:0]          err_cnt_r;
    logic [15:0]          meas_r;

    logic [BIT_DEPTH-1:0] edge_vec_s;
    logic                 edge_found_s;
    logic                 glitch_s;
    logic [2:0]           edge_phase_s;
    logic                 at_p_s;
    logic                 good_s;
    logic                 ref_s;
    logic                 revo_s;
    logic                 perr_s;
    logic                 err_s;

    // Edge detection: a bit is an edge when set while its predecessor in time is clear
    always_comb begin
        edge_vec_s   = word_in & ~{prev_lsb_r, word_in[BIT_DEPTH-1:1]};
        edge_found_s = |edge_vec_s;
        glitch_s     = |(edge_vec_s & (edge_vec_s - {{(BIT_DEPTH-1){1'b0}}, 1'b1}));
        edge_phase_s = 3'd0;
        // Ascending scan so the highest (earliest-in-time) edge wins
        for (int i = 0; i < BIT_DEPTH; i++) begin
            if (edge_vec_s[i]) begin
                edge_phase_s = 3'(BIT_DEPTH - 1 - i);
            end else begin
                edge_phase_s = edge_phase_s;
            end
        end
    end

    // Lock FSM next-state and event decode
    always_comb begin
        state_s     = state_r;
        ref_phase_s = ref_phase_r;
        matches_s   = matches_r;
        misses_s    = misses_r;
        ref_s       = 1'b0;
        revo_s      = 1'b0;
        perr_s      = 1'b0;
        at_p_s      = (dist_r == PERIOD);
        good_s      = edge_found_s && at_p_s && (edge_phase_s == ref_phase_r);
        case (state_r)
            SEARCH: begin
                if (edge_found_s) begin
                    state_s     = VERIFY;
                    ref_s       = 1'b1;
                    ref_phase_s = edge_phase_s;
                    matches_s   = 8'd0;
                end else begin
                    matches_s   = 8'd0;
                end
            end
            VERIFY: begin
                if (good_s) begin
                    ref_s = 1'b1;
                    if ((matches_r + 8'd1) == LOCK_C) begin
                        state_s   = LOCKED;
                        revo_s    = 1'b1;
                        matches_s = 8'd0;
                        misses_s  = 8'd0;
                    end else begin
                        matches_s = matches_r + 8'd1;
                    end
                end else if (edge_found_s) begin
                    perr_s      = 1'b1;
                    ref_s       = 1'b1;
                    ref_phase_s = edge_phase_s;
                    matches_s   = 8'd0;
                end else if (dist_r > PERIOD) begin
                    state_s   = SEARCH;
                    matches_s = 8'd0;
                end else begin
                    state_s = VERIFY;
                end
            end
            LOCKED: begin
                if (good_s) begin
                    revo_s   = 1'b1;
                    misses_s = 8'd0;
                    ref_s    = 1'b1;
                end else if (at_p_s) begin
                    // Missed period: advance the reference to the predicted edge word
                    perr_s = 1'b1;
                    ref_s  = 1'b1;
`ifdef REVO_FLYWHEEL_EN
                    revo_s = 1'b1;
`else
                    revo_s = 1'b0;
`endif
                    if ((misses_r + 8'd1) >= MISS_C) begin
                        state_s  = SEARCH;
                        misses_s = 8'd0;
                    end else begin
                        misses_s = misses_r + 8'd1;
                    end
                end else if (edge_found_s) begin
                    perr_s = 1'b1;
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                state_s   = SEARCH;
                matches_s = 8'd0;
                misses_s  = 8'd0;
            end
        endcase
        err_s = perr_s | glitch_s;
    end

    // Tracking state: FSM, distance counter, reference phase, previous LSB
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= SEARCH;
            prev_lsb_r  <= 1'b0;
            dist_r      <= 16'd0;
            ref_phase_r <= 3'd0;
            matches_r   <= 8'd0;
            misses_r    <= 8'd0;
        end else begin
            state_r     <= state_s;
            prev_lsb_r  <= word_in[0];
            ref_phase_r <= ref_phase_s;
            matches_r   <= matches_s;
            misses_r    <= misses_s;
            if (ref_s) begin
                dist_r <= 16'd1;
            end else if (dist_r != SAT) begin
                dist_r <= dist_r + 16'd1;
            end else begin
                dist_r <= dist_r;
            end
        end
    end

    // Registered outputs and error statistics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            revo_r    <= 1'b0;
            phase_r   <= 3'd0;
            locked_r  <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= 16'd0;
            meas_r    <= 16'd0;
        end else begin
            revo_r   <= revo_s;
            locked_r <= (state_s == LOCKED);
            err_r    <= err_s;
            phase_r  <= revo_s ? ref_phase_r : phase_r;
            meas_r   <= edge_found_s ? dist_r : meas_r;
            if (err_s && (err_cnt_r != SAT)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign revo            = revo_r;
    assign revo_bit_phase  = phase_r;
    assign locked          = locked_r;
    assign period_error    = err_r;
    assign error_count     = err_cnt_r;
    assign measured_period = meas_r;

endmodule

// File: tb/tb_revo_word_receiver.sv
// Self-checking bench for revo_word_receiver with a short period (16 words) and LOCK_COUNT=3;
// per-cycle expectations are queued when a word is driven and popped once its outputs are visible.
module tb_revo_word_receiver;

    typedef struct packed {
        logic       revo;
        logic [2:0] phase;
        logic       err;
    } exp_t;

`ifdef REVO_FLYWHEEL_EN
    localparam bit FLY = 1'b1;
`else
    localparam bit FLY = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [7:0]  word_in;
    logic        revo;
    logic [2:0]  revo_bit_phase;
    logic        locked;
    logic        period_error;
    logic [15:0] error_count;
    logic [15:0] measured_period;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    revo_word_receiver #(
        .BIT_DEPTH(8),
        .REVO_PERIOD_WORDS(16),
        .LOCK_COUNT(3),
        .MAX_MISSES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .word_in(word_in),
        .revo(revo),
        .revo_bit_phase(revo_bit_phase),
        .locked(locked),
        .period_error(period_error),
        .error_count(error_count),
        .measured_period(measured_period)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Training edges every 16 words starting at word 2
    function automatic bit is_edge(input int c);
        return (c >= 2) && (((c - 2) % 16) == 0);
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b0;
        word_in = 8'h00;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Queue the expectation for word w, drive it, and advance to where its outputs are visible
    task automatic send(input logic [7:0] w, input exp_t e);
        exp_q.push_back(e);
        word_in = w;
        @(negedge clock);
    endtask

    task automatic test_reset();
        exp_t e;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            word_in = 8'($urandom);
            @(negedge clock);
        end
        n_cmp++;
        if ({revo, revo_bit_phase, locked, period_error, error_count, measured_period} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got revo=%b ph=%0d lk=%b err=%b cnt=%0d meas=%0d want all 0",
                     revo, revo_bit_phase, locked, period_error, error_count, measured_period);
        end
        reset = 1'b1;
        for (int c = 0; c < 40; c++) begin
            send(8'h00, '{revo: 1'b0, phase: 3'd0, err: 1'b0});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || error_count !== 16'd0) begin
                n_bad++;
                $display("FAIL idle_zero c=%0d revo=%b err=%b cnt=%0d want 0/0/0", c, revo, period_error, error_count);
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 82; c++) begin
            send(is_edge(c) ? 8'h1F : 8'h00, '{revo: is_edge(c) && c >= 50, phase: 3'd3, err: 1'b0});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || (e.revo && revo_bit_phase !== e.phase)
                || locked !== (c >= 50)) begin
                n_bad++;
                $display("FAIL lock c=%0d revo=%b/%b err=%b/%b ph=%0d/%0d lk=%b/%b", c, revo, e.revo,
                         period_error, e.err, revo_bit_phase, e.phase, locked, c >= 50);
            end
            if (is_edge(c) && c > 2) begin
                n_cmp++;
                if (measured_period !== 16'd16) begin
                    n_bad++;
                    $display("FAIL lock_period c=%0d got %0d want 16", c, measured_period);
                end
            end else if (c == 2) begin
                n_cmp++;
                if (measured_period !== 16'd2) begin
                    n_bad++;
                    $display("FAIL first_period got %0d want 2", measured_period);
                end
            end
        end
        n_cmp++;
        if (error_count !== 16'd0) begin
            n_bad++;
            $display("FAIL lock_errcnt got %0d want 0", error_count);
        end
    endtask

    task automatic test_miss(input int n_miss);
        exp_t e;
        bit   gone;
        bit   lk;
        do_reset();
        for (int c = 0; c <= 115; c++) begin
            gone = (c == 82) || (n_miss == 2 && c == 98);
            lk   = (c >= 50) && !(n_miss == 2 && c >= 98);
            send((is_edge(c) && !gone) ? 8'h1F : 8'h00,
                 '{revo: is_edge(c) && c >= 50 && (!gone || FLY) && !(n_miss == 2 && c > 98),
                   phase: 3'd3, err: gone});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || (e.revo && revo_bit_phase !== e.phase)
                || locked !== lk) begin
                n_bad++;
                $display("FAIL miss%0d c=%0d revo=%b/%b err=%b/%b ph=%0d/%0d lk=%b/%b", n_miss, c, revo, e.revo,
                         period_error, e.err, revo_bit_phase, e.phase, locked, lk);
            end
        end
        n_cmp++;
        if (error_count !== 16'(n_miss)) begin
            n_bad++;
            $display("FAIL miss%0d_errcnt got %0d want %0d", n_miss, error_count, n_miss);
        end
    endtask

    task automatic test_extra_edge();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 83; c++) begin
            send(is_edge(c) ? 8'h1F : ((c == 73) ? 8'h80 : 8'h00),
                 '{revo: is_edge(c) && c >= 50, phase: 3'd3, err: c == 73});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || (e.revo && revo_bit_phase !== e.phase)
                || locked !== (c >= 50)) begin
                n_bad++;
                $display("FAIL extra c=%0d revo=%b/%b err=%b/%b ph=%0d/%0d lk=%b", c, revo, e.revo,
                         period_error, e.err, revo_bit_phase, e.phase, locked);
            end
            if (c == 73 || c == 82) begin
                n_cmp++;
                if (measured_period !== ((c == 73) ? 16'd7 : 16'd16)) begin
                    n_bad++;
                    $display("FAIL extra_period c=%0d got %0d", c, measured_period);
                end
            end
        end
        n_cmp++;
        if (error_count !== 16'd1) begin
            n_bad++;
            $display("FAIL extra_errcnt got %0d want 1", error_count);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 52; c++) begin
            send(is_edge(c) ? 8'h44 : 8'h00, '{revo: is_edge(c) && c >= 50, phase: 3'd1, err: is_edge(c)});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || (e.revo && revo_bit_phase !== e.phase)
                || locked !== (c >= 50)) begin
                n_bad++;
                $display("FAIL glitch c=%0d revo=%b/%b err=%b/%b ph=%0d/%0d lk=%b", c, revo, e.revo,
                         period_error, e.err, revo_bit_phase, e.phase, locked);
            end
        end
        n_cmp++;
        if (error_count !== 16'd4) begin
            n_bad++;
            $display("FAIL glitch_errcnt got %0d want 4", error_count);
        end
    endtask

    task automatic test_reset_midlock();
        exp_t e;
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            send(is_edge(c) ? 8'h1F : ((c == 57) ? 8'h80 : 8'h00),
                 '{revo: is_edge(c) && c >= 50, phase: 3'd3, err: c == 57});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || locked !== (c >= 50)) begin
                n_bad++;
                $display("FAIL midlock_pre c=%0d revo=%b/%b err=%b/%b lk=%b", c, revo, e.revo,
                         period_error, e.err, locked);
            end
        end
        n_cmp++;
        if (error_count !== 16'd1) begin
            n_bad++;
            $display("FAIL midlock_pre_errcnt got %0d want 1", error_count);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (locked !== 1'b0 || error_count !== 16'd0 || revo !== 1'b0) begin
            n_bad++;
            $display("FAIL midlock_async lk=%b cnt=%0d revo=%b want 0/0/0", locked, error_count, revo);
        end
        @(negedge clock);
        reset   = 1'b1;
        word_in = 8'h00;
        for (int c = 0; c <= 51; c++) begin
            send(is_edge(c) ? 8'h1F : 8'h00, '{revo: c == 50, phase: 3'd3, err: 1'b0});
            e = exp_q.pop_front();
            n_cmp++;
            if (revo !== e.revo || period_error !== e.err || (e.revo && revo_bit_phase !== e.phase)
                || locked !== (c >= 50)) begin
                n_bad++;
                $display("FAIL relock c=%0d revo=%b/%b err=%b/%b ph=%0d lk=%b", c, revo, e.revo,
                         period_error, e.err, revo_bit_phase, locked);
            end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        word_in = 8'h00;
        test_reset();
        test_lock();
        test_miss(1);
        test_miss(2);
        test_extra_edge();
        test_glitch();
        test_reset_midlock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
